sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised successor to the team's 8-bit single-clock FIFO. It has configurable data width and depth, and selects between registered-output and first-word-fall-through read modes at elaboration time. It adds programmable almost-full and almost-empty thresholds, plus sticky overflow and underflow error flags. It sits between a producer and a consumer in one clock domain and replaces the fixed FIFO in new datapaths.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries. Must be a power of two and >=2.
- AFULL_TH, 14, almost_full asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.
- FWFT, 0, read mode.
  - 0: registered output, data arrives one cycle after read.
  - 1: first-word-fall-through, head word visible on dout while !empty.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- dout  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  number of stored words.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - Read pointer, write pointer and count go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
  - Storage contents are don't-care. All state takes effect immediately, without waiting for a clock edge.
- Write acceptance:
  - Accepted iff wr_en && !full. din is stored at wr_ptr, and wr_ptr increments modulo DEPTH on the same edge.
  - A write while full is dropped: storage is unchanged and overflow is set.
- Read acceptance:
  - Accepted iff rd_en && !empty. rd_ptr increments modulo DEPTH.
  - A read while empty is ignored: dout holds and underflow is set.
- Simultaneous read and write:
  - Each request is evaluated against the pre-edge flags.
  - Not full and not empty: both are accepted and count is unchanged.
  - Empty: the write is accepted, the read is rejected (underflow set), and count becomes 1.
  - Full: the read is accepted, the write is rejected (overflow set), and count becomes DEPTH-1.
  - There is no write-through or bypass path.
- Count and flags:
  - count is registered: +1 on an accepted write only, -1 on an accepted read only.
  - full, empty, almost_full and almost_empty are registered. Each is consistent with count in the same cycle, i.e. it is updated on the same edge as count.
- Pointers:
  - Binary, $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - The count register disambiguates full from empty when the pointers are equal.
- FWFT=0 (registered output):
  - dout is loaded with mem[rd_ptr] on the edge that accepts a read, so data is valid one cycle after rd_en.
  - dout holds its value otherwise.
- FWFT=1 (fall-through):
  - dout = mem[rd_ptr] whenever !empty. rd_en pops the word.
  - A word written into an empty FIFO is visible on dout in the cycle after the write edge, when empty deasserts.
  - dout is don't-care while empty.
- Sticky errors:
  - overflow and underflow stay set until clr_err or rst.
  - If clr_err and a new error event occur on the same edge, the set wins.
- Parameter checks: illegal parameter values are flagged at elaboration by a simulation-only $error in an initial block.
- Storage is a plain register array with no reset, so it can be inferred as distributed RAM.

Test Plan:
1. Reset check (DEPTH=4, FWFT=0): assert rst for 3 cycles, release.
   -> empty=1, almost_empty=1, full=0, count=0, dout=0, overflow=0, underflow=0.
2. Fill and overflow (DEPTH=4, AFULL_TH=3): write 0xA1, 0xB2, 0xC3, 0xD4, then 0xE5 with full high.
   -> almost_full rises when count=3, full rises when count=4.
   -> 0xE5 is dropped and overflow=1 sticks.
   -> Subsequent reads return A1, B2, C3, D4 in order, each one cycle after rd_en.
3. Drain, underflow and clear: read the 4 words, then assert rd_en again with the FIFO empty.
   -> empty=1 and underflow=1, and dout still 0xD4.
   -> One cycle of clr_err clears both overflow and underflow.
4. Simultaneous read and write at count=2, held for 10 cycles (DEPTH=4), including pointer wrap past index 3.
   -> count stays 2 and the output order matches the input order.
   -> Additionally, at empty with wr_en and rd_en high: count becomes 1 and underflow=1.
   -> At full with both high: count becomes 3 and overflow=1.
5. FWFT=1 fall-through: write 0x5A into the empty FIFO.
   -> The next cycle shows empty=0 and dout=0x5A with no rd_en.
   -> rd_en for one cycle gives empty=1 and count=0.
6. Mid-operation reset: at count=3, pulse rst asynchronously between clock edges.
   -> All outputs return to their reset values immediately.
   -> The next write of 0x77 followed by a read returns 0x77.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with elaboration-time width, depth and read mode, programmable
// almost-full/almost-empty thresholds, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AfullC  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_TH);

`ifndef SYNTHESIS
  initial begin
    if (DATA_W < 1) $error("sync_fifo_param: DATA_W must be >= 1");
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) $error("sync_fifo_param: AFULL_TH out of 1..DEPTH");
    if (AEMPTY_TH > DEPTH - 1) $error("sync_fifo_param: AEMPTY_TH out of 0..DEPTH-1");
    if (FWFT > 1) $error("sync_fifo_param: FWFT must be 0 or 1");
  end
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered (pre-edge) flags only.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    // A new error event outranks a simultaneous clear.
    if (wr_en && full_q)  overflow_d  = 1'b1;
    if (rd_en && empty_q) underflow_d = 1'b1;
    full_d   = (count_d == DepthC);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfullC);
    aempty_d = (count_d <= AemptyC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // No reset on storage so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = empty_q ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_ptr_q];
      end
    end
    assign dout = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-output and a fall-through instance share
// stimulus and are checked against a queue-based model plus fixed vector tables.
module tb_sync_fifo_param;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] din;

  logic [DW-1:0] dout_r, dout_f;
  logic          full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [2:0]    count_r, count_f;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_r),
    .full(full_r), .empty(empty_r), .almost_full(af_r), .almost_empty(ae_r),
    .count(count_r), .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, sticky flags, registered read word.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  typedef struct {
    bit            wr;
    logic [DW-1:0] d;
    bit            rd;
    bit            clr;
    int            cnt;
    bit            full;
    bit            empty;
    bit            af;
    bit            ae;
    bit            ovf;
    bit            unf;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    int n = q.size();
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (wr && n == DP) m_ovf = 1'b1;
    if (rd && n == 0) m_unf = 1'b1;
    if (rd && n > 0) m_dout = q.pop_front();
    if (wr && n < DP) q.push_back(d);
  endtask

  task automatic check_model();
    int n = q.size();
    chk("count_r", 32'(count_r), 32'(n));
    chk("count_f", 32'(count_f), 32'(n));
    chk("full_r", 32'(full_r), 32'(n == DP));
    chk("full_f", 32'(full_f), 32'(n == DP));
    chk("empty_r", 32'(empty_r), 32'(n == 0));
    chk("empty_f", 32'(empty_f), 32'(n == 0));
    chk("afull_r", 32'(af_r), 32'(n >= AF));
    chk("afull_f", 32'(af_f), 32'(n >= AF));
    chk("aempty_r", 32'(ae_r), 32'(n <= AE));
    chk("aempty_f", 32'(ae_f), 32'(n <= AE));
    chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
    chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
    chk("unf_r", 32'(unf_r), 32'(m_unf));
    chk("unf_f", 32'(unf_f), 32'(m_unf));
    chk("dout_r", 32'(dout_r), 32'(m_dout));
    if (n > 0) chk("dout_f", 32'(dout_f), 32'(q[0]));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
    wr_en   = wr;
    din     = d;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    model_edge(wr, d, rd, clr);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"}, 32'(empty_r), 32'd1);
    chk({tag, "_aempty"}, 32'(ae_r), 32'd1);
    chk({tag, "_full"}, 32'(full_r), 32'd0);
    chk({tag, "_afull"}, 32'(af_r), 32'd0);
    chk({tag, "_count"}, 32'(count_r), 32'd0);
    chk({tag, "_dout"}, 32'(dout_r), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_r), 32'd0);
    chk({tag, "_unf"}, 32'(unf_r), 32'd0);
    chk({tag, "_empty_f"}, 32'(empty_f), 32'd1);
    chk({tag, "_count_f"}, 32'(count_f), 32'd0);
  endtask

  initial begin
    // Fill, overflow, drain, underflow, clear (registered-output view).
    vecs[0]  = '{1, 8'hA1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[1]  = '{1, 8'hB2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{1, 8'hC3, 0, 0, 3, 0, 0, 1, 0, 0, 0, 8'h00};
    vecs[3]  = '{1, 8'hD4, 0, 0, 4, 1, 0, 1, 0, 0, 0, 8'h00};
    vecs[4]  = '{1, 8'hE5, 0, 0, 4, 1, 0, 1, 0, 1, 0, 8'h00};
    vecs[5]  = '{0, 8'h00, 1, 0, 3, 0, 0, 1, 0, 1, 0, 8'hA1};
    vecs[6]  = '{0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 1, 0, 8'hB2};
    vecs[7]  = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0, 8'hC3};
    vecs[8]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 0, 8'hD4};
    vecs[9]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 1, 8'hD4};
    vecs[10] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'hD4};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
      chk($sformatf("tbl%0d_count", i), 32'(count_r), 32'(vecs[i].cnt));
      chk($sformatf("tbl%0d_full", i), 32'(full_r), 32'(vecs[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty_r), 32'(vecs[i].empty));
      chk($sformatf("tbl%0d_afull", i), 32'(af_r), 32'(vecs[i].af));
      chk($sformatf("tbl%0d_aempty", i), 32'(ae_r), 32'(vecs[i].ae));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf_r), 32'(vecs[i].ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(unf_r), 32'(vecs[i].unf));
      chk($sformatf("tbl%0d_dout", i), 32'(dout_r), 32'(vecs[i].dout));
    end

    // Simultaneous read/write while empty: write wins, read underflows.
    step(1, 8'h11, 1, 0);
    chk("rw_empty_count", 32'(count_r), 32'd1);
    chk("rw_empty_unf", 32'(unf_r), 32'd1);
    step(1, 8'h22, 0, 1);
    chk("rw_clr_unf", 32'(unf_r), 32'd0);
    // Steady state at count 2 across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'($urandom), 1, 0);
      chk("rw_steady_count", 32'(count_r), 32'd2);
    end
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    // Simultaneous read/write while full: read wins, write overflows.
    step(1, 8'h55, 1, 0);
    chk("rw_full_count", 32'(count_r), 32'd3);
    chk("rw_full_ovf", 32'(ovf_r), 32'd1);

    // Asynchronous reset between edges at count 3.
    #3 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    #1 rst = 1'b0;
    model_reset();
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("midrst_readback", 32'(dout_r), 32'h77);

    // Fall-through: written word visible without a read, popped by one read.
    step(1, 8'h5A, 0, 0);
    chk("fwft_empty", 32'(empty_f), 32'd0);
    chk("fwft_dout", 32'(dout_f), 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("fwft_pop_empty", 32'(empty_f), 32'd1);
    chk("fwft_pop_count", 32'(count_f), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
